// File: rtl/ff_ga_pkg.sv
// Shared types, command codes and fixed-point helpers for the ff_ga geometry accelerator.
// Values are signed Q16.16. Matrices are row-major, so element (i,j) is at index i*4+j.
package ff_ga_pkg;

  typedef logic signed [31:0] fx_t;
  typedef fx_t [0:15] mat4_t;
  typedef fx_t [0:3]  vec4_t;

  localparam logic [31:0] CMD_MATRIX = 32'd0;
  localparam logic [31:0] CMD_VERTEX = 32'd1;
  localparam logic [31:0] CMD_RESULT = 32'd2;

  localparam fx_t FX_ONE = 32'sh0001_0000;

  localparam mat4_t IDENTITY = {
    FX_ONE, 32'sd0,  32'sd0,  32'sd0,
    32'sd0, FX_ONE,  32'sd0,  32'sd0,
    32'sd0, 32'sd0,  FX_ONE,  32'sd0,
    32'sd0, 32'sd0,  32'sd0,  FX_ONE
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_M,
    ST_COMMIT,
    ST_LOAD_V,
    ST_READ
  } state_t;

  // A Q32.32 product or sum becomes Q16.16 by keeping bits [47:16] (floor toward -inf).
  function automatic fx_t fxTrunc(input logic [63:0] v);
    return fx_t'(v >> 16);
  endfunction

endpackage

// File: rtl/ff_ga_mul_array.sv
// Sixteen signed 32x32->64 multipliers shared between matrix composition and vertex transform.
// Product g corresponds to row g/4 and column g%4 of the 4x4 grid.
module ff_ga_mul_array
  import ff_ga_pkg::*;
(
  input  logic [0:15][31:0] i_c,
  input  logic [0:3][31:0]  i_data,
  input  logic [1:0]        i_row,
  input  logic              i_outer,
  output logic [0:15][63:0] o_prod,
  output logic [0:3][63:0]  o_dot
);

  logic [0:15][63:0] w_prod;

  // Outer mode pairs C[i][row] with data[j]; dot mode pairs C[i][j] with data[j].
  for (genvar g = 0; g < 16; g++) begin : gMul
    localparam logic [1:0] ROW = 2'(g / 4);
    localparam logic [1:0] COL = 2'(g % 4);
    logic [3:0]          w_idx;
    logic signed [31:0]  w_a;
    logic signed [31:0]  w_b;

    assign w_idx     = {ROW, i_row};
    assign w_a       = i_outer ? i_c[w_idx] : i_c[g];
    assign w_b       = i_data[COL];
    assign w_prod[g] = 64'(w_a) * 64'(w_b);
  end

  for (genvar r = 0; r < 4; r++) begin : gDot
    assign o_dot[r] = w_prod[r*4] + w_prod[r*4+1] + w_prod[r*4+2] + w_prod[r*4+3];
  end

  assign o_prod = w_prod;

endmodule

// File: rtl/ff_ga.sv
// Geometry accelerator top: holds the composite transform C, composes it with loaded matrices
// (C = C*M) and transforms four-vertex blocks into the result matrix R read back by column.
module ff_ga
  import ff_ga_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic [0:3][31:0] data_in,
  output logic [0:3][31:0] data_out,
  output logic             rdy
);

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_cnt;
  logic [1:0]        w_sel;
  logic              w_outer;
  mat4_t             r_c;
  mat4_t             r_r;
  logic [0:15][63:0] r_acc;
  logic [0:15][63:0] w_prod;
  logic [0:3][63:0]  w_dot;

  assign w_outer = (r_state == ST_LOAD_M);

  ff_ga_mul_array u_mul (
    .i_c     (r_c),
    .i_data  (data_in),
    .i_row   (r_cnt),
    .i_outer (w_outer),
    .o_prod  (w_prod),
    .o_dot   (w_dot)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (addr == CMD_MATRIX)      w_next = ST_LOAD_M;
        else if (addr == CMD_VERTEX) w_next = ST_LOAD_V;
        else if (addr == CMD_RESULT) w_next = ST_READ;
      end
      ST_LOAD_M: if (r_cnt == 2'd3) w_next = ST_COMMIT;
      ST_COMMIT: w_next = ST_IDLE;
      ST_LOAD_V: if (r_cnt == 2'd3) w_next = ST_IDLE;
      ST_READ:   if (r_cnt == 2'd3) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rdy   = (r_state == ST_IDLE);
    w_sel = (r_state == ST_READ) ? r_cnt : 2'd0;
  end

  // READ starts at column 1 because column 0 is already on data_out during the accept cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    r_cnt <= 2'd0;
    else if (r_state == ST_IDLE) r_cnt <= (addr == CMD_RESULT) ? 2'd1 : 2'd0;
    else                         r_cnt <= r_cnt + 2'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_c   <= IDENTITY;
      r_r   <= '0;
      r_acc <= '0;
    end else begin
      case (r_state)
        ST_LOAD_M: begin
          for (int g = 0; g < 16; g++) r_acc[g] <= r_acc[g] + w_prod[g];
        end
        ST_COMMIT: begin
          for (int g = 0; g < 16; g++) begin
            r_c[g]   <= fxTrunc(r_acc[g]);
            r_acc[g] <= '0;
          end
        end
        ST_LOAD_V: begin
          for (int i = 0; i < 4; i++) r_r[{2'(i), r_cnt}] <= fxTrunc(w_dot[i]);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    data_out = '0;
    for (int i = 0; i < 4; i++) data_out[i] = r_r[{2'(i), w_sel}];
  end

endmodule

// File: tb/tb_ff_ga.sv
// Scoreboard bench for ff_ga: a reference model predicts each result column when a vertex
// block is loaded, and the columns are popped and compared as the RESULT readout walks them.
module tb_ff_ga;
  import ff_ga_pkg::*;

  typedef logic [0:3][31:0]  vec_t;
  typedef logic [0:15][31:0] mat_t;

  localparam logic [31:0] NOCMD = 32'd3;
  localparam logic [31:0] ONE   = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  vec_t        data_in;
  vec_t        data_out;
  logic        rdy;

  int   checkCount = 0;
  int   passCount  = 0;
  mat_t modelC;
  vec_t expQ[$];

  ff_ga dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .rdy      (rdy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
  endtask

  function automatic mat_t identityMat();
    mat_t m = '0;
    for (int i = 0; i < 4; i++) m[i*5] = ONE;
    return m;
  endfunction

  function automatic mat_t composeMat(input mat_t c, input mat_t m);
    mat_t   r;
    longint s;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int k = 0; k < 4; k++)
          s += longint'($signed(c[i*4+k])) * longint'($signed(m[k*4+j]));
        r[i*4+j] = s[47:16];
      end
    return r;
  endfunction

  function automatic vec_t transformVec(input mat_t c, input vec_t v);
    vec_t   r;
    longint s;
    for (int i = 0; i < 4; i++) begin
      s = 0;
      for (int k = 0; k < 4; k++)
        s += longint'($signed(c[i*4+k])) * longint'($signed(v[k]));
      r[i] = s[47:16];
    end
    return r;
  endfunction

  function automatic vec_t colOf(input mat_t m, input int j);
    vec_t v;
    for (int k = 0; k < 4; k++) v[k] = m[j*4+k];
    return v;
  endfunction

  task automatic loadMatrix(input mat_t m, input string tag);
    @(negedge clk);
    addr = CMD_MATRIX;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      addr = NOCMD;
      checkOutput($sformatf("%s_rdy_row%0d", tag, k), rdy, 1'b0);
      for (int j = 0; j < 4; j++) data_in[j] = m[k*4+j];
    end
    @(negedge clk);
    data_in = '0;
    checkOutput({tag, "_rdy_commit"}, rdy, 1'b0);
    @(negedge clk);
    checkOutput({tag, "_rdy_back"}, rdy, 1'b1);
    modelC = composeMat(modelC, m);
  endtask

  task automatic loadVertices(input mat_t verts, input string tag);
    vec_t row;
    @(negedge clk);
    addr = CMD_VERTEX;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      addr = NOCMD;
      for (int k = 0; k < 4; k++) row[k] = verts[j*4+k];
      data_in = row;
      expQ.push_back(transformVec(modelC, row));
    end
    @(negedge clk);
    data_in = '0;
    checkOutput({tag, "_rdy_after_vertex"}, rdy, 1'b1);
  endtask

  task automatic readResult(input string tag, output mat_t cols);
    vec_t exp0;
    vec_t expv;
    checkOutput({tag, "_sb_depth"}, 128'(expQ.size()), 128'(4));
    @(negedge clk);
    addr = CMD_RESULT;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) @(negedge clk);
      if (j == 1) addr = NOCMD;
      expv = (expQ.size() > 0) ? expQ.pop_front() : 'x;
      if (j == 0) exp0 = expv;
      for (int k = 0; k < 4; k++) cols[j*4+k] = data_out[k];
      checkOutput($sformatf("%s_col%0d", tag, j), data_out, expv);
    end
    @(negedge clk);
    checkOutput({tag, "_col0_again"}, data_out, exp0);
    checkOutput({tag, "_rdy_end"}, rdy, 1'b1);
  endtask

  // Main stimulus sequence.
  initial begin
    mat_t verts;
    mat_t cols;
    mat_t tMat;
    mat_t sMat;
    mat_t nMat;
    vec_t passExp;

    rst     = 1'b0;
    addr    = NOCMD;
    data_in = '0;
    modelC  = identityMat();

    repeat (3) @(negedge clk);
    checkOutput("reset_rdy", rdy, 1'b1);
    checkOutput("reset_dout", data_out, '0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_dout", data_out, '0);

    verts    = '0;
    verts[0] = ONE;
    verts[3] = ONE;
    loadVertices(verts, "pass");
    readResult("pass", cols);
    passExp = {ONE, 32'd0, 32'd0, ONE};
    checkOutput("pass_identity_col0", colOf(cols, 0), passExp);

    @(negedge clk);
    addr = 32'd455;
    @(negedge clk);
    addr = NOCMD;
    checkOutput("bogus_rdy", rdy, 1'b1);
    checkOutput("bogus_dout", data_out, passExp);
    @(negedge clk);
    checkOutput("bogus_rdy_hold", rdy, 1'b1);

    tMat     = identityMat();
    tMat[3]  = 32'h012C_0000;
    sMat     = '0;
    sMat[0]  = 32'h0005_0000;
    sMat[5]  = 32'h0005_0000;
    sMat[10] = 32'h0005_0000;
    sMat[15] = ONE;
    loadMatrix(tMat, "transl");
    loadMatrix(sMat, "scale");
    verts    = '0;
    verts[0] = ONE;
    verts[1] = ONE;
    verts[3] = ONE;
    loadVertices(verts, "compose");
    readResult("compose", cols);
    checkOutput("compose_x_305", cols[0], 32'h0131_0000);
    checkOutput("compose_y_5", cols[1], 32'h0005_0000);

    @(negedge clk);
    addr = CMD_MATRIX;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      addr = NOCMD;
      for (int j = 0; j < 4; j++) data_in[j] = sMat[k*4+j];
    end
    @(negedge clk);
    rst     = 1'b0;
    data_in = '0;
    @(negedge clk);
    checkOutput("midreset_rdy", rdy, 1'b1);
    checkOutput("midreset_dout", data_out, '0);
    rst    = 1'b1;
    modelC = identityMat();
    expQ.delete();

    verts = {32'h0003_0000, 32'hFFFE_0000, 32'h0007_8000, ONE,
             32'h0000_4000, 32'h0010_0000, 32'hFFFF_C000, ONE,
             32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000,
             32'hFFF0_0000, 32'h0000_0001, 32'h7FFF_0000, ONE};
    loadVertices(verts, "after_reset");
    readResult("after_reset", cols);
    checkOutput("after_reset_passthrough", colOf(cols, 0),
                {32'h0003_0000, 32'hFFFE_0000, 32'h0007_8000, ONE});

    nMat     = '0;
    nMat[0]  = 32'hFFFF_8000;
    nMat[5]  = 32'hFFFF_8000;
    nMat[10] = 32'hFFFF_8000;
    nMat[15] = 32'hFFFF_8000;
    loadMatrix(nMat, "neg");
    verts = {32'h0002_0000, 32'h0002_0000, 32'h0002_0000, ONE,
             32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000,
             32'hFFFD_0000, 32'h0000_8000, 32'h0000_0003, ONE,
             32'h0064_0000, 32'hFF9C_0000, 32'h0000_0000, 32'h0002_0000};
    loadVertices(verts, "neg");
    readResult("neg", cols);
    checkOutput("neg_x", cols[0], 32'hFFFF_0000);
    checkOutput("neg_y", cols[1], 32'hFFFF_0000);
    checkOutput("neg_z", cols[2], 32'hFFFF_0000);
    checkOutput("neg_w", cols[3], 32'hFFFF_8000);

    loadMatrix(tMat, "stable");
    for (int j = 0; j < 4; j++) expQ.push_back(colOf(cols, j));
    readResult("r_stable", cols);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ff_ga.md
# ff_ga

Fixed-function geometry accelerator for a rasterising pipeline. It holds a signed Q16.16 4x4 composite transform and post-multiplies it by each loaded matrix, OpenGL style: C = C·M. It transforms blocks of four homogeneous vertices by C and returns the results one vertex per cycle. It sits on a simple address/data command port driven by the host or bench.

## Interface
- No parameters.
- clk  in  1  sole clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- addr  in  32  command: 0 = MATRIX, 1 = VERTEX, 2 = RESULT. Any other value means no command.
- data_in  in  [0:3][32]  one row per cycle, Q16.16 signed.
- data_out  out  [0:3][32]  one result column per cycle: x, y, z, w of one vertex.
- rdy  out  1  high only in IDLE.

## Operation
- States: IDLE, LOAD_M (row counter 0..3), COMMIT, LOAD_V (row counter 0..3), READ (column counter 1..3).
- Commands are sampled only in IDLE. addr is ignored in every other state.
- IDLE, addr=0 -> LOAD_M.
  - Each cycle, row k of M is sampled from data_in.
  - acc[i][j] += C[i][k]·M[k][j]; all 16 products are full-precision 64-bit signed.
  - After row 3 -> COMMIT.
- COMMIT (1 cycle):
  - C[i][j] <= acc[i][j][47:16].
  - acc is cleared.
  - Next state IDLE.
- IDLE, addr=1 -> LOAD_V.
  - Row j on data_in is vertex v_j = {x, y, z, w}.
  - R column j <= Σk C[i][k]·v_j[k], summed in 64 bits, then bits [47:16] taken.
  - After row 3 -> IDLE. All of R is valid from that edge.
- IDLE, addr=2 -> READ, with column counter 1; it walks 1, 2, 3, then returns to IDLE.
- data_out = R column sel:
  - sel = 0 in every state except READ.
  - in READ, sel = the column counter.
- Arithmetic:
  - Truncation is an arithmetic shift (toward −inf).
  - Sums wrap in 64 bits.
  - No saturation.
- Reset values:
  - C = identity (diagonal 0x00010000, others 0).
  - R = 0, acc = 0.
  - State IDLE, so rdy = 1 and data_out = 0.

## Timing
- Command accept: the edge at which IDLE sees addr ∈ {0, 1, 2}. rdy falls 1 cycle later.
- LOAD_M, LOAD_V: data rows are sampled on the 4 edges following accept, one row per edge, with no stalls.
- Matrix latency:
  - 4 data edges + 1 COMMIT edge.
  - The next command can be accepted at the edge after COMMIT → IDLE, i.e. the first edge with rdy = 1.
- Vertex latency:
  - Zero extra cycles. The state is back in IDLE at the edge that samples row 3.
  - Column 0 is visible on data_out from that edge.
- READ output:
  - The cycle in which IDLE samples addr=2 shows column 0.
  - The following three cycles show columns 1, 2, 3.
  - Then IDLE, and column 0 is shown again.
- Reset mid-operation: immediately returns to reset values. A partially loaded matrix or vertex block is discarded.
- A new MATRIX load never changes R. A VERTEX load never changes C.

## Structure
- Package ff_ga_pkg:
  - typedef fx_t (signed 32-bit Q16.16), mat4_t ([0:15] fx_t), vec4_t.
  - Command constants CMD_MATRIX=0, CMD_VERTEX=1, CMD_RESULT=2.
  - FX_ONE = 32'h0001_0000, IDENTITY.
  - State enum.
- One sub-module, ff_ga_mul_array:
  - 16 signed 32x32→64 multipliers driven by C and data_in.
  - In LOAD_M mode it outputs the outer-product terms C[i][k]·data_in[j].
  - In LOAD_V mode it outputs per-row dot-product sums.
  - The top level holds the FSM, C, acc and R.

## Test plan
- Reset: hold rst=0, release.
  - Expect rdy=1 and data_out=0.
  - VERTEX (1,0,0,1)·FX_ONE (other rows 0), then RESULT → column 0 = 0x00010000, 0, 0, 0x00010000, i.e. identity C passes the vertex through.
- Protocol check:
  - rdy is 0 through LOAD_M and COMMIT, and returns to 1 exactly 5 cycles after accept.
  - Bogus addr=455 in IDLE → no state change.
- Composition order:
  - Load translate-x 300 (C[3] = 0x012C0000), then scale 5.
  - Vertex (1,1,0,1) → x = 0x01310000 (305), y = 0x00050000.
  - The reverse order must not be produced; it would give x = 1505.
- Negative fixed point: a matrix with diagonal 0xFFFF8000 (−0.5) times vertex (2,2,2,1) → 0xFFFF0000 on x, y, z.
- Readout order:
  - With four distinct vertices, the columns appear in order 0..3 on consecutive cycles after addr=2.
  - Column 0 appears again in IDLE.
- Reset mid-operation: assert rst after 2 rows of a MATRIX load → C returns to identity and the state is IDLE.
